// File: rtl/change_pkg.sv
// Shared types and constants for the change dispenser: FSM states, change
// code width and coin values in 5-cent units.
package change_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VEND,
    S_DIME,
    S_NICKEL,
    S_GAP,
    S_DONE
  } state_t;

  localparam int unsigned CHANGE_W         = 3;
  localparam int unsigned MAX_CHANGE_UNITS = 4;
  localparam int unsigned NICKEL_UNITS     = 1;
  localparam int unsigned DIME_UNITS       = 2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Down-counting interval timer: load N, then expired is high in the Nth cycle
// after the load and stays high until the next load.
module pulse_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count;

  // Loading value-1 makes the expiry cycle the last cycle of the interval.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value - W'(1);
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Vend-then-pay change dispenser with a single pending-request slot in front
// of a dispense FSM that shares one interval timer across all timed states.
module change_dispenser
  import change_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_soda,
  input  logic [CHANGE_W-1:0] i_change,
  input  logic                i_vend_ack,
  output logic                o_vend,
  output logic                o_dime_out,
  output logic                o_nickel_out,
  output logic                o_done,
  output logic                o_busy,
  output logic                o_overflow,
  output logic                o_bad_code,
  output logic                o_fault
);

  localparam int unsigned TIMER_W = $clog2(max3(PULSE_CYCLES, GAP_CYCLES, ACK_TIMEOUT) + 1);

  state_t              state, state_next, coin_state;
  logic                pend_valid;
  logic [CHANGE_W-1:0] pend_change;
  logic [1:0]          dimes, dimes_next;
  logic                nickel, nickel_next;
  logic                consume, code_ok, accept, set_fault;
  logic                load, expired;
  logic [TIMER_W-1:0]  load_value;

  assign code_ok = (i_change <= CHANGE_W'(MAX_CHANGE_UNITS));
  assign consume = (state == S_IDLE) && pend_valid;
  // The slot may be refilled in the same cycle the FSM drains it.
  assign accept  = i_soda && code_ok && (!pend_valid || consume);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_valid  <= 1'b0;
      pend_change <= '0;
      o_overflow  <= 1'b0;
      o_bad_code  <= 1'b0;
    end else begin
      if (accept) begin
        pend_valid  <= 1'b1;
        pend_change <= i_change;
      end else if (consume) begin
        pend_valid <= 1'b0;
      end
      if (i_soda && !code_ok) o_bad_code <= 1'b1;
      if (i_soda && code_ok && !accept) o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      dimes   <= '0;
      nickel  <= 1'b0;
      o_fault <= 1'b0;
    end else begin
      state  <= state_next;
      dimes  <= dimes_next;
      nickel <= nickel_next;
      if (set_fault) o_fault <= 1'b1;
    end
  end

  always_comb begin
    if (dimes != '0)  coin_state = S_DIME;
    else if (nickel)  coin_state = S_NICKEL;
    else              coin_state = S_DONE;
  end

  always_comb begin
    state_next   = state;
    dimes_next   = dimes;
    nickel_next  = nickel;
    set_fault    = 1'b0;
    o_vend       = 1'b0;
    o_dime_out   = 1'b0;
    o_nickel_out = 1'b0;
    o_done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend_valid) begin
          state_next  = S_VEND;
          dimes_next  = 2'(pend_change / CHANGE_W'(DIME_UNITS));
          nickel_next = pend_change[0];
        end
      end
      S_VEND: begin
        o_vend = 1'b1;
        if (i_vend_ack) begin
          state_next = coin_state;
        end else if (expired) begin
          set_fault  = 1'b1;
          state_next = coin_state;
        end
      end
      S_DIME: begin
        o_dime_out = 1'b1;
        if (expired) begin
          state_next = S_GAP;
          dimes_next = dimes - 2'd1;
        end
      end
      S_NICKEL: begin
        o_nickel_out = 1'b1;
        if (expired) begin
          state_next  = S_GAP;
          nickel_next = 1'b0;
        end
      end
      S_GAP: begin
        if (expired) state_next = coin_state;
      end
      S_DONE: begin
        o_done     = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Every transition changes state, so a state change marks each entry.
  always_comb begin
    load = (state_next != state);
    case (state_next)
      S_VEND:            load_value = TIMER_W'(ACK_TIMEOUT);
      S_DIME, S_NICKEL:  load_value = TIMER_W'(PULSE_CYCLES);
      S_GAP:             load_value = TIMER_W'(GAP_CYCLES);
      default:           load_value = '0;
    endcase
  end

  pulse_timer #(
    .W(TIMER_W)
  ) u_timer (
    .clk    (i_clk),
    .rst    (i_rst),
    .load   (load),
    .value  (load_value),
    .expired(expired)
  );

  assign o_busy = pend_valid || (state != S_IDLE);

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench: a schedule-based transaction model is compared with
// the DUT every cycle, plus literal per-case cycle counts.
module tb_change_dispenser;

  localparam int unsigned PULSE  = 4;
  localparam int unsigned GAPC   = 2;
  localparam int unsigned ACK_TO = 8;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_soda = 1'b0;
  logic [2:0] i_change = 3'd0;
  logic       i_vend_ack = 1'b0;
  logic       o_vend, o_dime_out, o_nickel_out, o_done;
  logic       o_busy, o_overflow, o_bad_code, o_fault;

  change_dispenser #(
    .PULSE_CYCLES(PULSE),
    .GAP_CYCLES  (GAPC),
    .ACK_TIMEOUT (ACK_TO)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_soda      (i_soda),
    .i_change    (i_change),
    .i_vend_ack  (i_vend_ack),
    .o_vend      (o_vend),
    .o_dime_out  (o_dime_out),
    .o_nickel_out(o_nickel_out),
    .o_done      (o_done),
    .o_busy      (o_busy),
    .o_overflow  (o_overflow),
    .o_bad_code  (o_bad_code),
    .o_fault     (o_fault)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Transaction model: one pending slot, one active transaction which is
  // either waiting for ack or playing a precomputed {dime,nickel,done} list.
  bit         m_active, m_in_vend, m_pend_valid, m_ovf, m_bad, m_fault;
  int         m_vcnt, m_cur, m_pend_change;
  logic [2:0] m_sched[$];

  function automatic void build_sched(input int change);
    m_sched.delete();
    for (int d = 0; d < change / 2; d++) begin
      repeat (PULSE) m_sched.push_back(3'b100);
      repeat (GAPC)  m_sched.push_back(3'b000);
    end
    if (change % 2 == 1) begin
      repeat (PULSE) m_sched.push_back(3'b010);
      repeat (GAPC)  m_sched.push_back(3'b000);
    end
    m_sched.push_back(3'b001);
  endfunction

  function automatic logic [7:0] exp_vec();
    logic [2:0] coin = 3'b000;
    logic       vend = 1'b0;
    if (m_active && m_in_vend) vend = 1'b1;
    else if (m_active && m_sched.size() > 0) coin = m_sched[0];
    return {vend, coin, (m_pend_valid || m_active), m_ovf, m_bad, m_fault};
  endfunction

  always @(posedge i_clk) begin
    bit consume;
    if (i_rst) begin
      m_active = 0; m_in_vend = 0; m_pend_valid = 0;
      m_ovf = 0; m_bad = 0; m_fault = 0; m_vcnt = 0;
      m_sched.delete();
    end else begin
      consume = !m_active && m_pend_valid;
      if (consume) begin
        m_active = 1; m_in_vend = 1; m_vcnt = 0; m_cur = m_pend_change;
        m_pend_valid = 0;
      end else if (m_active && m_in_vend) begin
        m_vcnt++;
        if (i_vend_ack || m_vcnt == ACK_TO) begin
          if (!i_vend_ack) m_fault = 1;
          m_in_vend = 0;
          build_sched(m_cur);
        end
      end else if (m_active) begin
        void'(m_sched.pop_front());
        if (m_sched.size() == 0) m_active = 0;
      end
      if (i_soda) begin
        if (i_change > 3'd4) m_bad = 1;
        else if (!m_pend_valid) begin
          m_pend_valid = 1; m_pend_change = int'(i_change);
        end else m_ovf = 1;
      end
    end
  end

  int cnt_vend, cnt_dime, cnt_nick, cnt_done, cnt_vrise;
  logic prev_vend = 1'b0;

  always @(negedge i_clk) begin
    logic [7:0] got, exp;
    got = {o_vend, o_dime_out, o_nickel_out, o_done, o_busy, o_overflow, o_bad_code, o_fault};
    exp = exp_vec();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cycle_outputs t=%0t got=%b exp=%b (vend,dime,nick,done,busy,ovf,bad,fault)",
               $time, got, exp);
    end
    cnt_vend  += int'(o_vend === 1'b1);
    cnt_dime  += int'(o_dime_out === 1'b1);
    cnt_nick  += int'(o_nickel_out === 1'b1);
    cnt_done  += int'(o_done === 1'b1);
    cnt_vrise += int'(o_vend === 1'b1 && prev_vend !== 1'b1);
    prev_vend = o_vend;
  end

  // Vend motor stand-in: acks once o_vend has been high for ack_delay+1 cycles.
  int ack_delay = 0;
  int vcnt = 0;
  always @(posedge i_clk) begin
    #1;
    if (o_vend === 1'b1) vcnt++;
    else vcnt = 0;
    i_vend_ack = (o_vend === 1'b1) && (vcnt > ack_delay);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic soda(input logic [2:0] ch);
    i_soda = 1'b1; i_change = ch;
    tick(1);
    i_soda = 1'b0; i_change = 3'd7;
  endtask

  task automatic clear_cnts();
    cnt_vend = 0; cnt_dime = 0; cnt_nick = 0; cnt_done = 0; cnt_vrise = 0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (o_busy !== 1'b0 && n < 300) begin
      tick(1);
      n++;
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout got=busy exp=idle", name);
    end
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    i_rst = 1'b0;
    check("reset_busy", int'(o_busy), 0);
    check("reset_flags", int'({o_overflow, o_bad_code, o_fault}), 0);

    // Case 1: no change, ack on third o_vend cycle
    ack_delay = 2; clear_cnts();
    soda(3'd0);
    check("lat_before_vend", int'(o_vend), 0);
    tick(1);
    check("lat_vend_high", int'(o_vend), 1);
    wait_idle("c1");
    check("c1_vend_cycles", cnt_vend, 3);
    check("c1_coins", cnt_dime + cnt_nick, 0);
    check("c1_done", cnt_done, 1);

    // Case 2: 15 cents, prompt ack
    ack_delay = 0; clear_cnts();
    soda(3'd3);
    wait_idle("c2");
    check("c2_vend_cycles", cnt_vend, 1);
    check("c2_dime_cycles", cnt_dime, 4);
    check("c2_nick_cycles", cnt_nick, 4);
    check("c2_done", cnt_done, 1);

    // Case 3: 20 cents
    clear_cnts();
    soda(3'd4);
    wait_idle("c3");
    check("c3_dime_cycles", cnt_dime, 8);
    check("c3_nick_cycles", cnt_nick, 0);

    // Case 4: queued second request, third one overflows
    clear_cnts();
    soda(3'd3);
    tick(3);
    soda(3'd1);
    tick(2);
    soda(3'd2);
    check("c4_overflow", int'(o_overflow), 1);
    wait_idle("c4");
    check("c4_vends", cnt_vrise, 2);
    check("c4_done", cnt_done, 2);
    check("c4_dime_cycles", cnt_dime, 4);
    check("c4_nick_cycles", cnt_nick, 8);

    // Case 5: ack never arrives
    ack_delay = 1000; clear_cnts();
    soda(3'd2);
    wait_idle("c5");
    check("c5_vend_cycles", cnt_vend, 8);
    check("c5_fault", int'(o_fault), 1);
    check("c5_dime_cycles", cnt_dime, 4);
    check("c5_done", cnt_done, 1);

    // Case 6a: bad change code
    ack_delay = 0;
    i_rst = 1'b1; tick(1); i_rst = 1'b0;
    clear_cnts();
    soda(3'd6);
    tick(3);
    check("c6_bad_code", int'(o_bad_code), 1);
    check("c6_no_vend", cnt_vend, 0);
    check("c6_not_busy", int'(o_busy), 0);

    // Case 6b: reset in the middle of a dime pulse
    soda(3'd4);
    for (int n = 0; n < 50 && o_dime_out !== 1'b1; n++) tick(1);
    check("c6_dime_seen", int'(o_dime_out), 1);
    tick(1);
    i_rst = 1'b1;
    tick(1);
    check("c6_rst_outputs", int'({o_vend, o_dime_out, o_nickel_out, o_done,
                                  o_busy, o_overflow, o_bad_code, o_fault}), 0);
    i_rst = 1'b0;
    clear_cnts();
    tick(20);
    check("c6_no_done", cnt_done, 0);
    check("c6_no_vend_after", cnt_vend, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Sits directly downstream of the vending controller FSM and consumes its one-cycle dispense pulse (soda request plus change code).
- Drives the soda vend motor through a request/acknowledge handshake.
- Then ejects change greedily as dimes followed by at most one nickel, using timed ejector pulses.
- Holds one pending request, so back-to-back sales are not lost while a dispense is in progress.

Parameters:
- PULSE_CYCLES, 4, cycles each ejector output is held high per coin (≥1).
- GAP_CYCLES, 2, low cycles after each coin pulse before the next action (≥1).
- ACK_TIMEOUT, 255, cycles o_vend may wait for i_vend_ack before fault (≥1).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_soda  in  1  one-cycle dispense pulse from the vending FSM.
- i_change  in  3  change owed in 5¢ units; 0–4 valid (0¢–20¢). Sampled only when i_soda=1.
- i_vend_ack  in  1  vend motor done; level, sampled in VEND only.
- o_vend  out  1  vend motor request; level, held until ack or timeout.
- o_dime_out  out  1  dime ejector drive.
- o_nickel_out  out  1  nickel ejector drive.
- o_done  out  1  one-cycle pulse when a transaction completes.
- o_busy  out  1  high when pending register is valid or FSM is not IDLE.
- o_overflow  out  1  sticky: a request was dropped because both slots were full.
- o_bad_code  out  1  sticky: a request arrived with i_change ∈ {5,6,7}.
- o_fault  out  1  sticky: vend ack timeout occurred.

Behaviour:
- Reset (sync, i_rst=1 at edge):
  - FSM→IDLE; pending cleared; all counters 0.
  - All outputs 0, including sticky flags.
  - Mid-operation reset truncates any ejector pulse and o_vend on the next edge; the in-flight transaction is discarded.
- Capture stage:
  - i_soda=1 with i_change≤4 writes the pending register {change} and sets pend_valid.
  - Accepted if pend_valid=0, or if the FSM consumes pending in that same cycle.
  - Otherwise dropped; o_overflow set.
  - i_change≥5: request dropped, o_bad_code set, pending untouched.
  - i_change is ignored while i_soda=0.
- Dispense FSM states:
  - IDLE: if pend_valid → load dimes=change>>1, nickel=change[0]; clear pend_valid; go to VEND.
  - VEND:
    - o_vend=1 while here.
    - i_vend_ack=1 → next state by remaining coins: dimes>0 → DIME, else nickel → NICKEL, else DONE.
    - Wait counter reaching ACK_TIMEOUT without ack → set o_fault and proceed identically, so change is still paid.
  - DIME: o_dime_out=1 for exactly PULSE_CYCLES cycles → GAP; dimes decrements on exit.
  - NICKEL: o_nickel_out=1 for PULSE_CYCLES → GAP; nickel cleared on exit.
  - GAP:
    - All drives low for GAP_CYCLES.
    - Then dimes>0 → DIME, else nickel → NICKEL, else DONE.
  - DONE: o_done=1 for one cycle → IDLE.
- Latency:
  - i_soda at edge t → pend_valid at t+1 → o_vend high from t+2 (empty pipe).
  - A pending request queued behind an active one starts VEND 2 cycles after that one's o_done.
- Output constraints:
  - o_dime_out and o_nickel_out are never high together.
  - Neither ejector is active while o_vend=1.
- Widths: timer counter $clog2(max(PULSE_CYCLES, GAP_CYCLES, ACK_TIMEOUT)+1) bits; dime count 2 bits.

Decomposition:
- Package change_pkg holds:
  - state enum (IDLE, VEND, DIME, NICKEL, GAP, DONE);
  - CHANGE_W=3 and MAX_CHANGE_UNITS=4;
  - coin value constants (NICKEL=1, DIME=2 units).
- Sub-module pulse_timer:
  - load/count/expire counter;
  - shared by PULSE, GAP and ACK timeout;
  - reloaded on every state entry.

Test Plan:
- Params 4/2/8 for all cases.
- Case 1: i_soda, change=0, ack 3 cycles after o_vend rises → o_vend high 3 cycles; no ejector activity; o_done pulse; busy falls.
- Case 2: change=3 (15¢), prompt ack → dime pulse 4 cycles, gap 2, nickel pulse 4 cycles, gap 2, o_done.
- Case 3: change=4 → two 4-cycle dime pulses separated by 2 low cycles; o_nickel_out never asserts.
- Case 4: second i_soda (change=1) during first transaction → served after o_done (o_vend 2 cycles later); a third request while both slots are full → o_overflow=1, only two vends occur.
- Case 5: i_vend_ack held 0, change=2 → o_vend drops after 8 cycles, o_fault=1, one dime still ejected, o_done pulses.
- Case 6: i_change=6 → o_bad_code=1, no o_vend. Separately, i_rst asserted mid dime pulse → all outputs 0 on the next edge; FSM IDLE; no o_done.
